// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall vector width,
// stall encodings, FSM states and the stall priority encoder.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Bit i freezes stage i: [0]pc [1]if [2]id [3]ex [4]lsu [5]wb
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_LSU  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [STALL_W-1:0] stall_encode(input logic id_req,
                                                      input logic ex_req,
                                                      input logic lsu_req);
    if (lsu_req)     return STALL_LSU;
    else if (ex_req) return STALL_EX;
    else if (id_req) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// LSU bus-wait watchdog: counts consecutive lsu_stall_req cycles and pulses
// fire on the TIMEOUT_CYC-th one. TIMEOUT_CYC=0 disables it.
module pipe_ctrl_wdog #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int          CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lsu_stall_req,
  output logic fire
);

  localparam bit               WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] LAST  = WD_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] wd_cnt;

  assign fire = WD_EN && lsu_stall_req && (wd_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!lsu_stall_req || fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, branch/jump flush with deferred
// issue behind LSU waits, and LSU watchdog. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int          CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               lsu_stall_req,
  input  logic               ex_jump_req,
  input  logic [31:0]        ex_jump_addr,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic               bus_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_cnt
`endif
);

  state_t             state;
  logic [31:0]        pend_pc;
  logic               wd_fire;
  logic               jump_ok;
  logic [STALL_W-1:0] stall_c;
  logic               flush_c;
  logic [31:0]        flush_pc_c;

  pipe_ctrl_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wdog (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_stall_req (lsu_stall_req),
    .fire          (wd_fire)
  );

  // A jump from a stalled EX is not yet final; it will be re-presented.
  assign jump_ok = ex_jump_req & ~ex_stall_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pend_pc <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_ok && lsu_stall_req) begin
            pend_pc <= ex_jump_addr;
            // A timeout unfreezes EX this cycle, so issue without waiting.
            state   <= wd_fire ? ST_FLUSH : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!lsu_stall_req || wd_fire) state <= ST_FLUSH;
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stall_c    = STALL_NONE;
    flush_c    = 1'b0;
    flush_pc_c = '0;
    case (state)
      ST_RUN: begin
        if (jump_ok && !lsu_stall_req) begin
          flush_c    = 1'b1;
          flush_pc_c = ex_jump_addr;
        end else begin
          stall_c = stall_encode(id_stall_req, ex_stall_req, lsu_stall_req);
        end
      end
      ST_WAIT:  stall_c = stall_encode(id_stall_req, ex_stall_req, lsu_stall_req);
      ST_FLUSH: begin
        flush_c    = 1'b1;
        flush_pc_c = pend_pc;
      end
      default: ;
    endcase
    if (wd_fire) stall_c = STALL_NONE;
  end

  // Outputs are combinational from requests, so reset must mask them directly.
  assign stall       = rst_n ? stall_c    : STALL_NONE;
  assign flush       = rst_n & flush_c;
  assign flush_pc    = rst_n ? flush_pc_c : '0;
  assign bus_timeout = rst_n & wd_fire;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall != STALL_NONE) stall_cycles <= stall_cycles + 32'd1;
      if (flush)               flush_cnt    <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (watchdog instances with
// TIMEOUT_CYC=4 and TIMEOUT_CYC=0).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_stall_req;
  logic        ex_stall_req;
  logic        lsu_stall_req;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;

  logic [5:0]  stall,    stall0;
  logic        flush,    flush0;
  logic [31:0] flush_pc, flush_pc0;
  logic        bus_timeout, bus_timeout0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, stall_cycles0;
  logic [31:0] flush_cnt,    flush_cnt0;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_stall_req  (id_stall_req),
    .ex_stall_req  (ex_stall_req),
    .lsu_stall_req (lsu_stall_req),
    .ex_jump_req   (ex_jump_req),
    .ex_jump_addr  (ex_jump_addr),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .bus_timeout   (bus_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_cnt     (flush_cnt)
`endif
  );

  pipe_ctrl #(.TIMEOUT_CYC(0), .CNT_W(8)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_stall_req  (id_stall_req),
    .ex_stall_req  (ex_stall_req),
    .lsu_stall_req (lsu_stall_req),
    .ex_jump_req   (ex_jump_req),
    .ex_jump_addr  (ex_jump_addr),
    .stall         (stall0),
    .flush         (flush0),
    .flush_pc      (flush_pc0),
    .bus_timeout   (bus_timeout0)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles0),
    .flush_cnt     (flush_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs just after the edge, then settle for sampling.
  task automatic drive(input logic id, input logic ex, input logic lsu,
                       input logic jr, input logic [31:0] addr);
    @(posedge clk);
    #1;
    id_stall_req  = id;
    ex_stall_req  = ex;
    lsu_stall_req = lsu;
    ex_jump_req   = jr;
    ex_jump_addr  = addr;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] s, input logic f,
                            input logic [31:0] pc, input logic bt);
    check({tag, ".stall"},    32'(stall),       32'(s));
    check({tag, ".flush"},    32'(flush),       32'(f));
    check({tag, ".flush_pc"}, flush_pc,         pc);
    check({tag, ".timeout"},  32'(bus_timeout), 32'(bt));
  endtask

  initial begin
    // Reset asserted with every request active: outputs must stay quiet.
    rst_n = 1'b0;
    id_stall_req = 1'b1; ex_stall_req = 1'b0; lsu_stall_req = 1'b1;
    ex_jump_req = 1'b1; ex_jump_addr = 32'h55;
    #2;
    expect_out("reset", 6'b000000, 1'b0, 32'h0, 1'b0);
    #10;
    rst_n = 1'b1;
    id_stall_req = 1'b0; lsu_stall_req = 1'b0; ex_jump_req = 1'b0; ex_jump_addr = 32'h0;

    // Stall priority
    drive(1, 0, 0, 0, 32'h0); expect_out("id",     6'b000111, 1'b0, 32'h0, 1'b0);
    drive(1, 1, 0, 0, 32'h0); expect_out("id_ex",  6'b001111, 1'b0, 32'h0, 1'b0);
    drive(1, 1, 1, 0, 32'h0); expect_out("all",    6'b011111, 1'b0, 32'h0, 1'b0);
    drive(0, 0, 0, 0, 32'h0); expect_out("none",   6'b000000, 1'b0, 32'h0, 1'b0);

    // Immediate jump, jump over an ID stall, jump blocked by EX stall
    drive(0, 0, 0, 1, 32'h100); expect_out("jmp",      6'b000000, 1'b1, 32'h100, 1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("jmp_after",6'b000000, 1'b0, 32'h0,   1'b0);
    drive(1, 0, 0, 1, 32'h180); expect_out("jmp_id",   6'b000000, 1'b1, 32'h180, 1'b0);
    drive(0, 1, 0, 1, 32'h1c0); expect_out("jmp_ex",   6'b001111, 1'b0, 32'h0,   1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("idle1",    6'b000000, 1'b0, 32'h0,   1'b0);

    // Jump held behind a 3-cycle LSU wait, issued once after release
    drive(0, 0, 1, 1, 32'h200); expect_out("wait1", 6'b011111, 1'b0, 32'h0,   1'b0);
    drive(0, 0, 1, 1, 32'h200); expect_out("wait2", 6'b011111, 1'b0, 32'h0,   1'b0);
    drive(0, 0, 1, 1, 32'h200); expect_out("wait3", 6'b011111, 1'b0, 32'h0,   1'b0);
    drive(0, 0, 0, 1, 32'h200); expect_out("wait_rel", 6'b000000, 1'b0, 32'h0, 1'b0);
    drive(1, 0, 0, 1, 32'h999); expect_out("wflush", 6'b000000, 1'b1, 32'h200, 1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("wflush_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Watchdog: fires on the 4th consecutive cycle, then restarts
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 3; c++) begin
        drive(0, 0, 1, 0, 32'h0);
        expect_out($sformatf("wd%0d_c%0d", r, c), 6'b011111, 1'b0, 32'h0, 1'b0);
      end
      drive(0, 0, 1, 0, 32'h0);
      expect_out($sformatf("wd%0d_fire", r), 6'b000000, 1'b0, 32'h0, 1'b1);
      check($sformatf("wd0_never%0d", r), 32'(bus_timeout0), 32'h0);
      check($sformatf("wd0_stall%0d", r), 32'(stall0), 32'h1f);
    end
    drive(0, 0, 0, 0, 32'h0); expect_out("wd_drop", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Watchdog fires while a jump is pending in WAIT
    drive(0, 0, 1, 1, 32'h240); expect_out("wwd1", 6'b011111, 1'b0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 32'h240); expect_out("wwd2", 6'b011111, 1'b0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 32'h240); expect_out("wwd3", 6'b011111, 1'b0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 32'h240); expect_out("wwd_fire", 6'b000000, 1'b0, 32'h0, 1'b1);
    check("wwd0_never", 32'(bus_timeout0), 32'h0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("wwd_flush", 6'b000000, 1'b1, 32'h240, 1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("wwd_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Reset mid-WAIT discards the pending jump
    drive(0, 0, 1, 1, 32'h300); expect_out("rw1", 6'b011111, 1'b0, 32'h0, 1'b0);
    drive(0, 0, 1, 0, 32'h0);   expect_out("rw2", 6'b011111, 1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1 expect_out("rw_rst", 6'b000000, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lsu_stall_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 32'h0);
      expect_out($sformatf("rw_post%0d", c), 6'b000000, 1'b0, 32'h0, 1'b0);
    end

    // Five stalled cycles and two flushes since the last reset
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 0, 32'h0);
      check($sformatf("pf_stall%0d", c), 32'(stall), 32'h07);
    end
    drive(0, 0, 0, 1, 32'h400); expect_out("pf_j1", 6'b000000, 1'b1, 32'h400, 1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("pf_g1", 6'b000000, 1'b0, 32'h0,   1'b0);
    drive(0, 0, 0, 1, 32'h404); expect_out("pf_j2", 6'b000000, 1'b1, 32'h404, 1'b0);
    drive(0, 0, 0, 0, 32'h0);   expect_out("pf_g2", 6'b000000, 1'b0, 32'h0,   1'b0);
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles", stall_cycles, 32'd5);
    check("flush_cnt",    flush_cnt,    32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard controller that produces the 6-bit stall vector consumed by every pipeline register (pc, if_id, id_ex, ex_lsu, lsu_wb), together with the branch/jump flush.
- Prioritises stall requests from ID, EX and LSU.
- Holds a jump that is raised while younger stages are frozen, and issues it once the stall releases.
- Watchdogs LSU bus waits so a hung bus cannot freeze the core.

Parameters:
TIMEOUT_CYC, 255, consecutive lsu_stall_req cycles before forced abort; 0 disables the watchdog
CNT_W, 8, width of the watchdog counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_stall_req  in  1  load-use hazard detected in ID
ex_stall_req  in  1  multi-cycle EX operation (div) not finished
lsu_stall_req  in  1  LSU waiting on data bus
ex_jump_req  in  1  EX resolved a taken branch/jump
ex_jump_addr  in  32  jump target
stall  out  6  [0]pc [1]if [2]id [3]ex [4]lsu [5]wb
flush  out  1  squash IF/ID/EX contents and redirect PC
flush_pc  out  32  redirect target, valid when flush=1
bus_timeout  out  1  one-cycle pulse: LSU access aborted

Behaviour:
- Stall encoding is combinational from requests and state. Priority lsu > ex > id:
  - lsu → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - none → 6'b000000
- stall[5] is always 0. The vector is always a contiguous low-order run of ones, so exactly one stage (the first 0 after the run of 1s) inserts a bubble.
- Jump qualification: jump_ok = ex_jump_req & ~ex_stall_req.
- FSM states: RUN, WAIT, FLUSH.
- RUN:
  - jump_ok & ~lsu_stall_req: flush=1 and flush_pc=ex_jump_addr in the same cycle; stay in RUN.
  - jump_ok & lsu_stall_req: capture ex_jump_addr into pend_pc; flush=0; go to WAIT.
- WAIT:
  - stall follows the requests. ex_jump_req is ignored because the frozen EX re-presents the same jump and it must not be issued twice.
  - When lsu_stall_req=0 (or the watchdog fires), go to FLUSH.
- FLUSH: one cycle; flush=1, flush_pc=pend_pc, stall=6'b0 regardless of requests; go to RUN.
- flush_pc=0 whenever flush=0.
- Watchdog:
  - wd_cnt increments each cycle lsu_stall_req=1 and clears when it is 0.
  - When wd_cnt==TIMEOUT_CYC-1 with lsu_stall_req still 1: bus_timeout=1 for that cycle, stall=6'b0 for that cycle, and wd_cnt clears.
  - The LSU drops its request on bus_timeout.
  - TIMEOUT_CYC=0: bus_timeout is never asserted.
- Simultaneous events:
  - Watchdog fires in WAIT: that cycle has bus_timeout=1 and stall=0. The next cycle is FLUSH.
  - id_stall_req together with jump_ok in RUN: flush wins and stall=6'b0, because the flush kills the ID instruction.
- Reset (asynchronous, any time, including mid-WAIT): state=RUN, pend_pc=0, wd_cnt=0. While rst_n=0: stall=0, flush=0, flush_pc=0, bus_timeout=0. The pending jump is discarded.
- No output has more than combinational latency from its inputs, except FLUSH, which is one cycle after the stall release.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds output stall_cycles (32-bit), counting cycles with stall!=0, and output flush_cnt (32-bit), counting flush cycles.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - stall vector constants STALL_NONE, STALL_ID, STALL_EX, STALL_LSU
  - FSM state encodings
  - 6-bit stall width define
- Sub-module: pipe_ctrl_wdog, containing the counter, compare and pulse; parameterised by TIMEOUT_CYC and CNT_W.

Test Plan:
- id_stall_req=1 only → stall=6'b000111; adding ex_stall_req=1 → 6'b001111; adding lsu_stall_req=1 → 6'b011111.
- RUN, ex_jump_req=1, ex_jump_addr=0x0000_0100, no stalls → flush=1 and flush_pc=0x100 the same cycle; the next cycle flush=0.
- ex_jump_req=1 with addr 0x200 while lsu_stall_req=1 for 3 cycles → flush=0 throughout and no double issue; the cycle after lsu_stall_req drops, flush=1, flush_pc=0x200, stall=0.
- TIMEOUT_CYC=4, lsu_stall_req held high → bus_timeout=1 and stall=0 in the 4th cycle; wd_cnt then restarts; TIMEOUT_CYC=0 → never asserted.
- rst_n pulled low during WAIT with pend_pc=0x300 → outputs 0 immediately; after release, no flush is ever issued for 0x300.
- PIPE_CTRL_PERF_EN defined, 5 stalled cycles plus 2 flushes → stall_cycles=5, flush_cnt=2.
